// File: rtl/vec_alu_pkg.sv
// Shared types for the vector ALU sequencer and its operation decoder.
// Purpose : ALU control encoding, function-field constants and the
//           sequencer FSM state type.
// Ports   : none (package).
package vec_alu_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_MOV = 3'b010,
      ALU_MUL = 3'b011,
      ALU_DIV = 3'b100,
      ALU_CMP = 3'b101,
      ALU_NOP = 3'b110,
      ALU_DUP = 3'b111
   } alu_ctrl_t;

   // Low three funct bits; funct[3] is a don't-care for these operations.
   localparam logic [2:0] FUNCT_ADD = 3'b000;
   localparam logic [2:0] FUNCT_SUB = 3'b001;
   localparam logic [2:0] FUNCT_MUL = 3'b011;
   localparam logic [2:0] FUNCT_DIV = 3'b100;
   localparam logic [2:0] FUNCT_CMP = 3'b101;

   // Full four-bit encodings.
   localparam logic [3:0] FUNCT_MOV = 4'b1010;
   localparam logic [3:0] FUNCT_DUP = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_DIVWAIT = 2'd2,
      ST_DONE    = 2'd3
   } seq_state_t;

endpackage

// File: rtl/vec_alu_op_decode.sv
// Combinational decode of {alu_op, funct} into ALU control and SrcA select.
// Shared by the vector sequencer and the scalar path.
// Ports:
//   i_alu_op       1 = data-processing instruction
//   i_funct        function field
//   o_alu_control  ALU operation (NOP for non-DP and illegal encodings)
//   o_srca         SrcA select (only MOV selects 1)
//   o_is_div       operation is the multi-cycle divide
//   o_legal        0 for an undefined data-processing encoding
module vec_alu_op_decode
   import vec_alu_pkg::*;
(
   input  logic       i_alu_op,
   input  logic [3:0] i_funct,
   output alu_ctrl_t  o_alu_control,
   output logic       o_srca,
   output logic       o_is_div,
   output logic       o_legal
);

   always_comb begin
      o_alu_control = ALU_NOP;
      o_srca        = 1'b0;
      o_is_div      = 1'b0;
      o_legal       = 1'b1;
      if (i_alu_op) begin
         // MOV and DUP need all four bits; their low bits (010, 111) are not
         // otherwise used, so checking them first cannot shadow another op.
         if (i_funct == FUNCT_MOV) begin
            o_alu_control = ALU_MOV;
            o_srca        = 1'b1;
         end else if (i_funct == FUNCT_DUP) begin
            o_alu_control = ALU_DUP;
         end else begin
            case (i_funct[2:0])
               FUNCT_ADD: o_alu_control = ALU_ADD;
               FUNCT_SUB: o_alu_control = ALU_SUB;
               FUNCT_MUL: o_alu_control = ALU_MUL;
               FUNCT_DIV: begin
                  o_alu_control = ALU_DIV;
                  o_is_div      = 1'b1;
               end
               FUNCT_CMP: o_alu_control = ALU_CMP;
               default:   o_legal = 1'b0;
            endcase
         end
      end
   end

endmodule

// File: rtl/vec_alu_sequencer.sv
// Vector ALU sequencer: latches one decoded instruction and issues it to a
// LANES-wide ALU as ceil(vl/LANES) element-group beats with lane masks.
// Ports:
//   clk, reset    rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready  instruction handshake (in_ready high only in IDLE)
//   alu_op, funct, vl  instruction fields; vl above VLEN clamps to VLEN
//   beat_valid/beat_ready  beat handshake towards the ALU
//   alu_control, srca  decoded operation, held for the whole instruction
//   beat_idx, lane_mask, last  current beat descriptor
//   done, illegal  completion pulse; illegal marks an undefined encoding
//   dbg_state     current FSM state
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; once valid is raised the offered payload is held unchanged
// until that transfer. Every output comes from registers only.
module vec_alu_sequencer
   import vec_alu_pkg::*;
#(
   parameter  int LANES      = 4,
   parameter  int VLEN       = 16,
   parameter  int DIV_CYCLES = 4,
   localparam int VLW        = $clog2(VLEN) + 1,
   localparam int NGRP       = VLEN / LANES,
   localparam int IDXW       = (NGRP > 1) ? $clog2(NGRP) : 1
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             alu_op,
   input  logic [3:0]       funct,
   input  logic [VLW-1:0]   vl,
   output logic             beat_valid,
   input  logic             beat_ready,
   output logic [2:0]       alu_control,
   output logic             srca,
   output logic [IDXW-1:0]  beat_idx,
   output logic [LANES-1:0] lane_mask,
   output logic             last,
   output logic             done,
   output logic             illegal,
   output seq_state_t       dbg_state
);

   localparam int             LSH       = $clog2(LANES);
   localparam int             DCW       = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES - 1) : 1;
   localparam bit             DIV_WAITS = (DIV_CYCLES > 1);
   localparam logic [VLW-1:0] VLEN_V    = VLW'(VLEN);

   seq_state_t       r_state, w_next_state;
   alu_ctrl_t        r_alu_control;
   logic             r_srca, r_is_div, r_illegal;
   logic [IDXW-1:0]  r_nb_m1, r_beat_idx;
   logic [LANES-1:0] r_tail_mask;
   logic [DCW-1:0]   r_div_cnt;

   alu_ctrl_t        w_dec_ctrl;
   logic             w_dec_srca, w_dec_div, w_dec_legal;
   logic [VLW-1:0]   w_vl_clamped, w_vl_m1;
   logic [IDXW-1:0]  w_nb_m1;
   logic [LANES-1:0] w_tail_mask;
   logic             w_zero_beats;
   logic             w_accept, w_idx_inc, w_is_last;

   vec_alu_op_decode u_decode (
      .i_alu_op      (alu_op),
      .i_funct       (funct),
      .o_alu_control (w_dec_ctrl),
      .o_srca        (w_dec_srca),
      .o_is_div      (w_dec_div),
      .o_legal       (w_dec_legal)
   );

   // Instruction geometry: index of the last beat and the mask of the last
   // beat. The tail holds ((vl-1) mod LANES)+1 elements, so lane i is active
   // iff i <= (vl-1) mod LANES.
   always_comb begin
      w_vl_clamped = (vl > VLEN_V) ? VLEN_V : vl;
      w_vl_m1      = w_vl_clamped - VLW'(1);
      w_nb_m1      = '0;
      w_tail_mask  = '0;
      if (w_vl_clamped != '0) begin
         w_nb_m1 = IDXW'(w_vl_m1 >> LSH);
         for (int i = 0; i < LANES; i++) begin
            w_tail_mask[i] = (i <= int'(w_vl_m1 & VLW'(LANES - 1)));
         end
      end
      w_zero_beats = !alu_op || !w_dec_legal || (w_vl_clamped == '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_idx_inc    = 1'b0;
      w_is_last    = (r_beat_idx == r_nb_m1);
      case (r_state)
         ST_IDLE: begin
            if (in_valid) begin
               w_accept     = 1'b1;
               w_next_state = w_zero_beats ? ST_DONE : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (beat_ready) begin
               if (r_is_div && DIV_WAITS) w_next_state = ST_DIVWAIT;
               else if (w_is_last)        w_next_state = ST_DONE;
               else                       w_idx_inc    = 1'b1;
            end
         end
         ST_DIVWAIT: begin
            if (r_div_cnt == '0) begin
               if (w_is_last) begin
                  w_next_state = ST_DONE;
               end else begin
                  w_idx_inc    = 1'b1;
                  w_next_state = ST_ISSUE;
               end
            end
         end
         ST_DONE: w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_alu_control <= ALU_NOP;
         r_srca        <= 1'b0;
         r_is_div      <= 1'b0;
         r_illegal     <= 1'b0;
         r_nb_m1       <= '0;
         r_tail_mask   <= '0;
         r_beat_idx    <= '0;
         r_div_cnt     <= '0;
      end else begin
         if (w_accept) begin
            // The decoder already yields NOP/0 for non-DP and illegal encodings.
            r_alu_control <= w_dec_ctrl;
            r_srca        <= w_dec_srca;
            r_is_div      <= w_dec_div;
            r_illegal     <= !w_dec_legal;
            r_nb_m1       <= w_nb_m1;
            r_tail_mask   <= w_tail_mask;
            r_beat_idx    <= '0;
         end else if (w_idx_inc) begin
            r_beat_idx <= r_beat_idx + IDXW'(1);
         end
         // DIVWAIT lasts DIV_CYCLES-1 cycles: load DIV_CYCLES-2, leave at zero.
         if (r_state == ST_ISSUE && w_next_state == ST_DIVWAIT)
            r_div_cnt <= DCW'(DIV_CYCLES - 2);
         else if (r_state == ST_DIVWAIT && r_div_cnt != '0)
            r_div_cnt <= r_div_cnt - DCW'(1);
      end
   end

   assign in_ready    = (r_state == ST_IDLE);
   assign beat_valid  = (r_state == ST_ISSUE);
   assign last        = beat_valid && w_is_last;
   assign lane_mask   = !beat_valid ? '0 : (w_is_last ? r_tail_mask : '1);
   assign done        = (r_state == ST_DONE);
   assign illegal     = done && r_illegal;
   assign alu_control = r_alu_control;
   assign srca        = r_srca;
   assign beat_idx    = r_beat_idx;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_vec_alu_sequencer.sv
module tb_vec_alu_sequencer;
  import vec_alu_pkg::*;

  localparam int LANES = 4;
  localparam int VLEN  = 16;
  localparam int DC    = 4;
  localparam int VLW   = $clog2(VLEN) + 1;
  localparam int IDXW  = $clog2(VLEN / LANES);
  localparam int W     = IDXW + LANES + 1;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic             alu_op;
  logic [3:0]       funct;
  logic [VLW-1:0]   vl;
  logic             beat_valid;
  logic             beat_ready;
  logic [2:0]       alu_control;
  logic             srca;
  logic [IDXW-1:0]  beat_idx;
  logic [LANES-1:0] lane_mask;
  logic             last;
  logic             done;
  logic             illegal;
  seq_state_t       dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // expected beats of the instruction in flight: {idx, mask, last}
  logic [W-1:0] exp_q[$];

  vec_alu_sequencer #(.LANES(LANES), .VLEN(VLEN), .DIV_CYCLES(DC)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_op      (alu_op),
    .funct       (funct),
    .vl          (vl),
    .beat_valid  (beat_valid),
    .beat_ready  (beat_ready),
    .alu_control (alu_control),
    .srca        (srca),
    .beat_idx    (beat_idx),
    .lane_mask   (lane_mask),
    .last        (last),
    .done        (done),
    .illegal     (illegal),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode from the operation table.
  function automatic void ref_decode(input logic op, input logic [3:0] f,
                                     output logic [2:0] ctrl, output logic sa,
                                     output logic legal, output logic div);
    ctrl = 3'b110; sa = 1'b0; legal = 1'b1; div = 1'b0;
    if (op) begin
      if (f == 4'b1010) begin ctrl = 3'b010; sa = 1'b1; end
      else if (f == 4'b1111) ctrl = 3'b111;
      else begin
        case (int'(f) % 8)
          0: ctrl = 3'b000;
          1: ctrl = 3'b001;
          3: ctrl = 3'b011;
          4: begin ctrl = 3'b100; div = 1'b1; end
          5: ctrl = 3'b101;
          default: legal = 1'b0;
        endcase
      end
    end
  endfunction

  function automatic logic pick_ready(input int rmode, input int c);
    if (rmode == 0) return 1'b1;
    if (rmode == 1) return (c % 2) == 1;
    return 1'(($urandom_range(0, 1)));
  endfunction

  // Driver + scoreboard for one instruction. Starts and ends on a negedge.
  // rmode: 0 = beat_ready tied high, 1 = toggling 1/0, 2 = random.
  task automatic run_instr(input logic op, input logic [3:0] f, input int vlv, input int rmode);
    logic [2:0]       e_ctrl;
    logic             e_srca, e_legal, e_div;
    logic [IDXW-1:0]  e_idx;
    logic [LANES-1:0] e_mask;
    logic             e_last;
    int vlc, nb, c, last_acc, exp_done;
    bit finished;

    ref_decode(op, f, e_ctrl, e_srca, e_legal, e_div);
    vlc = (vlv > VLEN) ? VLEN : vlv;
    nb  = (op && e_legal) ? (vlc + LANES - 1) / LANES : 0;
    exp_q.delete();
    for (int b = 0; b < nb; b++) begin
      int cnt;
      logic [LANES-1:0] m;
      cnt = vlc - b * LANES;
      if (cnt > LANES) cnt = LANES;
      m = LANES'((1 << cnt) - 1);
      exp_q.push_back({IDXW'(b), m, (b == nb - 1)});
    end
    exp_done = (nb == 0) ? 1 : (e_div ? nb * DC + 1 : nb + 1);

    check("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1; alu_op = op; funct = f; vl = VLW'(vlv);
    beat_ready = 1'b1;
    @(negedge clk);
    // scramble the fields after the handshake; the DUT must have latched them
    in_valid = 1'b0;
    alu_op = 1'($urandom_range(0, 1)); funct = 4'($urandom_range(0, 15)); vl = VLW'($urandom_range(0, 20));
    c = 1; last_acc = -1; finished = 0;
    while (!finished && c <= 200) begin
      beat_ready = pick_ready(rmode, c);
      #1;
      if (beat_valid) begin
        if (exp_q.size() == 0) begin
          check("beat_unexpected", 1, 0);
        end else begin
          {e_idx, e_mask, e_last} = exp_q[0];
          check("beat_idx", beat_idx, e_idx);
          check("lane_mask", lane_mask, e_mask);
          check("last", last, e_last);
          check("beat_ctrl", alu_control, e_ctrl);
          check("beat_srca", srca, e_srca);
          if (e_div && last_acc >= 0) begin
            if (rmode == 0) check("div_spacing", c - last_acc, DC);
            else            check("div_spacing_min", (c - last_acc) >= DC, 1);
          end
          if (beat_ready) begin
            void'(exp_q.pop_front());
            last_acc = c;
          end
        end
      end
      if (done) begin
        check("beats_remaining", exp_q.size(), 0);
        check("illegal_flag", illegal, !e_legal);
        check("done_ctrl", alu_control, e_ctrl);
        check("done_srca", srca, e_srca);
        if (rmode == 0) check("done_cycle", c, exp_done);
        finished = 1;
      end else begin
        check("illegal_without_done", illegal, 0);
      end
      @(negedge clk);
      c++;
    end
    if (!finished) check("done_timeout", 0, 1);
    check("in_ready_after_done", in_ready, 1);
    check("done_one_cycle", done, 0);
  endtask

  // Reset while an ADD vl=16 is issuing, after beat 1 has been accepted.
  task automatic run_reset_abort();
    check("abort_in_ready", in_ready, 1);
    in_valid = 1'b1; alu_op = 1'b1; funct = 4'b0000; vl = VLW'(16); beat_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("abort_beat0_idx", beat_idx, 0);
    @(negedge clk);
    check("abort_beat1_idx", beat_idx, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_ready", in_ready, 1);
    check("abort_valid", beat_valid, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("abort_post_done", done, 0);
      check("abort_post_valid", beat_valid, 0);
      check("abort_post_ready", in_ready, 1);
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; alu_op = 1'b0; funct = 4'b0; vl = '0; beat_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_beat_valid", beat_valid, 0);
    check("rst_done", done, 0);
    check("rst_illegal", illegal, 0);
    check("rst_last", last, 0);
    check("rst_beat_idx", beat_idx, 0);
    check("rst_lane_mask", lane_mask, 0);
    check("rst_alu_control", alu_control, 3'b110);
    check("rst_srca", srca, 0);
    reset = 1'b0;
    @(negedge clk);

    run_reset_abort();

    run_instr(1'b1, 4'b0000, 16, 0);  // ADD, 4 full beats
    run_instr(1'b1, 4'b0001, 6, 1);   // SUB, stalls on the tail beat
    run_instr(1'b1, 4'b0100, 8, 0);   // DIV, paced beats
    run_instr(1'b1, 4'b1010, 5, 0);   // MOV
    run_instr(1'b1, 4'b0010, 9, 0);   // illegal
    run_instr(1'b0, 4'b0011, 12, 0);  // non-DP
    run_instr(1'b1, 4'b0000, 0, 0);   // vl = 0
    run_instr(1'b1, 4'b1000, 20, 0);  // clamped to 16
    run_instr(1'b1, 4'b1111, 3, 0);   // DUP
    run_instr(1'b1, 4'b1101, 13, 1);  // CMP, funct[3] set
    run_instr(1'b1, 4'b1011, 1, 0);   // MUL single lane
    run_instr(1'b1, 4'b1100, 7, 1);   // DIV with stalls

    for (int n = 0; n < 60; n++) begin
      run_instr(1'($urandom_range(0, 9) != 0), 4'($urandom_range(0, 15)),
                $urandom_range(0, 20), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
